// File: rtl/wb_arb_pkg.sv
// Shared encodings for the 2-master Wishbone memory arbiter: FSM states,
// one-hot grant values and the watchdog counter width helper.
package wb_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [0:0] {
    ARB_IDLE = ST_IDLE,
    ARB_BUSY = ST_BUSY
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // A disabled watchdog still gets a 1-bit counter so the port-free logic stays legal.
  function automatic int unsigned wd_cnt_width(input int unsigned cycles);
    int unsigned w;
    if (cycles == 0) w = 1;
    else             w = $clog2(cycles + 1);
    return w;
  endfunction

endpackage

// File: rtl/wb_rr_grant.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the
// master that was not served last.
module wb_rr_grant
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = GNT_NONE;
    case (req)
      2'b01:   grant = GNT_M0;
      2'b10:   grant = GNT_M1;
      2'b11:   grant = (last_grant == GNT_M1) ? GNT_M0 : GNT_M1;
      default: grant = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// 2-master -> 1-slave Wishbone-classic arbiter in front of the shared memory:
// round-robin grant, one transaction at a time, watchdog against a hung slave.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 16,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack,

  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack,

  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack,

  output logic [1:0]            grant_o,
  output logic                  timeout_o,
  input  logic                  timeout_clr_i
);

  localparam int unsigned    CW       = wd_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX  = '1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit             WD_ON    = (TIMEOUT_CYCLES != 0);

  arb_state_t            state;
  logic [1:0]            owner;
  logic [1:0]            last_grant;
  logic [1:0]            req;
  logic [1:0]            pick;
  logic [CW-1:0]         cnt;

  logic                  busy;
  logic                  own_cyc;
  logic                  own_stb;
  logic                  own_we;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic                  done_ack;
  logic                  abort;
  logic                  tmo;
  logic                  finish;
  logic [DATA_WIDTH-1:0] rdata;

  assign req  = {m1_cyc & m1_stb, m0_cyc & m0_stb};
  assign busy = (state == ARB_BUSY);

  wb_rr_grant u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_comb begin
    own_cyc   = owner[1] ? m1_cyc    : m0_cyc;
    own_stb   = owner[1] ? m1_stb    : m0_stb;
    own_we    = owner[1] ? m1_we     : m0_we;
    own_addr  = owner[1] ? m1_addr   : m0_addr;
    own_wdata = owner[1] ? m1_data_i : m0_data_i;
  end

  // Completion priority: slave ack, then a master abort, then the watchdog.
  always_comb begin
    done_ack = busy & s_ack;
    abort    = busy & ~s_ack & ~own_cyc;
    tmo      = WD_ON & busy & ~s_ack & own_cyc & (cnt == CNT_LAST);
    finish   = done_ack | tmo;
    rdata    = tmo ? TIMEOUT_DATA : s_data_i;
  end

  // owner is GNT_NONE outside BUSY, so every output collapses to zero in IDLE/reset.
  always_comb begin
    s_cyc     = busy & own_cyc;
    s_stb     = busy & own_stb;
    s_we      = busy & own_we;
    s_addr    = busy ? own_addr  : '0;
    s_data_o  = busy ? own_wdata : '0;
    m0_ack    = finish & owner[0];
    m1_ack    = finish & owner[1];
    m0_data_o = m0_ack ? rdata : '0;
    m1_data_o = m1_ack ? rdata : '0;
    grant_o   = owner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= GNT_NONE;
      last_grant <= GNT_M1;
      cnt        <= '0;
      timeout_o  <= 1'b0;
    end else begin
      if (tmo)                timeout_o <= 1'b1;
      else if (timeout_clr_i) timeout_o <= 1'b0;

      case (state)
        ARB_IDLE: begin
          cnt <= '0;
          if (|req) begin
            owner <= pick;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (finish) begin
            last_grant <= owner;
            owner      <= GNT_NONE;
            state      <= ARB_IDLE;
          end else if (abort) begin
            owner <= GNT_NONE;
            state <= ARB_IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          owner <= GNT_NONE;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: behavioural cycle model checked every cycle, a
// 1-cycle memory slave with optional delay/hang, and directed literal checks.
module tb_wb_mem_arbiter;

  localparam int          TMO      = 16;
  localparam logic [31:0] TMO_DATA = 32'hDEADBEEF;

  logic        clk, rst;
  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [31:0] m0_addr, m0_data_i, m0_data_o;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [31:0] m1_addr, m1_data_i, m1_data_o;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_addr, s_data_o, s_data_i;
  logic [1:0]  grant_o;
  logic        timeout_o, timeout_clr_i;

  int n_checks = 0;
  int n_fail   = 0;

  wb_mem_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_DATA   (TMO_DATA)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack(s_ack),
    .grant_o(grant_o), .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory slave: acks `delay` cycles after the first strobed cycle, never when hung.
  logic [31:0] mem [0:255];
  int          delay = 0;
  bit          hang  = 0;
  int          wcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack    <= 1'b0;
      s_data_i <= '0;
      wcnt     <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= i * 32'h01010101;
      mem[16] <= 32'h00001234;
    end else begin
      s_ack <= 1'b0;
      if (s_cyc && s_stb && !s_ack) begin
        if (!hang && wcnt >= delay) begin
          s_ack <= 1'b1;
          wcnt  <= 0;
          if (s_we) mem[s_addr[7:0]] <= s_data_o;
          else      s_data_i <= mem[s_addr[7:0]];
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  // Reference model: who owns the bus, who was served last, BUSY age, sticky flag.
  int mb_busy = 0, mb_own = 0, mb_last = 1, mb_cnt = 0, mb_tflag = 0;
  int nx_busy = 0, nx_own = 0, nx_last = 1, nx_cnt = 0, nx_tflag = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_busy = 0; mb_own = 0; mb_last = 1; mb_cnt = 0; mb_tflag = 0;
    end else begin
      mb_busy = nx_busy; mb_own = nx_own; mb_last = nx_last;
      mb_cnt = nx_cnt; mb_tflag = nx_tflag;
    end
  end

  always @(negedge clk) begin : cmp
    logic [1:0]  req;
    logic        ocyc, ostb, owe, ack_now, abort_now, to_now;
    logic [31:0] oaddr, odat, ret;
    logic [66:0] e_s;
    logic [32:0] e_m0, e_m1;
    logic [1:0]  e_g;
    req = {m1_cyc & m1_stb, m0_cyc & m0_stb};
    e_s = '0; e_m0 = '0; e_m1 = '0; e_g = '0;
    ack_now = 1'b0; abort_now = 1'b0; to_now = 1'b0;
    ocyc = 1'b0; ostb = 1'b0; owe = 1'b0; oaddr = '0; odat = '0; ret = '0;
    if (mb_busy != 0) begin
      if (mb_own == 0) begin
        ocyc = m0_cyc; ostb = m0_stb; owe = m0_we; oaddr = m0_addr; odat = m0_data_i;
      end else begin
        ocyc = m1_cyc; ostb = m1_stb; owe = m1_we; oaddr = m1_addr; odat = m1_data_i;
      end
      e_s       = {ocyc, ostb, owe, oaddr, odat};
      e_g       = (mb_own == 0) ? 2'b01 : 2'b10;
      ack_now   = s_ack;
      abort_now = !s_ack && !ocyc;
      to_now    = (TMO > 0) && !s_ack && ocyc && (mb_cnt == TMO - 1);
      if (ack_now || to_now) begin
        ret = ack_now ? s_data_i : TMO_DATA;
        if (mb_own == 0) e_m0 = {1'b1, ret};
        else             e_m1 = {1'b1, ret};
      end
    end
    check("slave_bus", {s_cyc, s_stb, s_we, s_addr, s_data_o}, e_s);
    check("m0_resp", {m0_ack, m0_data_o}, e_m0);
    check("m1_resp", {m1_ack, m1_data_o}, e_m1);
    check("grant", grant_o, e_g);
    check("timeout_flag", timeout_o, mb_tflag[0]);

    nx_busy = mb_busy; nx_own = mb_own; nx_last = mb_last; nx_cnt = mb_cnt;
    if (mb_busy == 0) begin
      if (req != 2'b00) begin
        nx_busy = 1;
        nx_cnt  = 0;
        if (req == 2'b11) nx_own = 1 - mb_last;
        else              nx_own = req[1] ? 1 : 0;
      end
    end else if (ack_now || to_now) begin
      nx_busy = 0;
      nx_last = mb_own;
    end else if (abort_now) begin
      nx_busy = 0;
    end else begin
      nx_cnt = mb_cnt + 1;
    end
    nx_tflag = to_now ? 1 : (timeout_clr_i ? 0 : mb_tflag);
  end

  task automatic drive_master(input int m, input bit en, input bit we,
                              input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_cyc = en; m0_stb = en; m0_we = we; m0_addr = a; m0_data_i = d;
    end else begin
      m1_cyc = en; m1_stb = en; m1_we = we; m1_addr = a; m1_data_i = d;
    end
  endtask

  // Called just after a rising edge; n = 0 is the request cycle.
  task automatic run_txn(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                         input int budget, output int stb_lat, output int ack_lat,
                         output logic [31:0] rdat, output logic [66:0] snap, output bit oth);
    drive_master(m, 1'b1, we, a, d);
    stb_lat = -1; ack_lat = -1; rdat = '0; snap = '0; oth = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (s_stb && stb_lat < 0) begin
        stb_lat = n;
        snap = {s_cyc, s_stb, s_we, s_addr, s_data_o};
      end
      if ((m == 0) ? m1_ack : m0_ack) oth = 1'b1;
      if ((m == 0) ? m0_ack : m1_ack) begin
        ack_lat = n;
        rdat = (m == 0) ? m0_data_o : m1_data_o;
        break;
      end
    end
    @(posedge clk); #1;
    drive_master(m, 1'b0, 1'b0, '0, '0);
  endtask

  int who [4];
  int when [4];

  // Both masters keep requesting until nacks acknowledges have been collected.
  task automatic stream_both(input int nacks, input int budget);
    int k;
    k = 0;
    for (int i = 0; i < 4; i++) begin who[i] = -1; when[i] = -1; end
    drive_master(0, 1'b1, 1'b0, 32'h10, '0);
    drive_master(1, 1'b1, 1'b0, 32'h20, '0);
    for (int n = 0; n < budget && k < nacks; n++) begin
      @(negedge clk);
      if (m0_ack && k < 4) begin who[k] = 0; when[k] = n; k++; end
      if (m1_ack && k < 4) begin who[k] = 1; when[k] = n; k++; end
    end
    @(posedge clk); #1;
    drive_master(0, 1'b0, 1'b0, '0, '0);
    drive_master(1, 1'b0, 1'b0, '0, '0);
  endtask

  int          st_lat, ak_lat;
  logic [31:0] rd;
  logic [66:0] snap;
  bit          oth, seen;
  int          exp_who [4];
  int          exp_when [4];

  initial begin
    rst = 1'b0; timeout_clr_i = 1'b0;
    drive_master(0, 1'b0, 1'b0, '0, '0);
    drive_master(1, 1'b0, 1'b0, '0, '0);
    exp_who  = '{0, 1, 0, 1};
    exp_when = '{2, 5, 8, 11};
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_grant", grant_o, 2'b00);
    check("reset_timeout", timeout_o, 1'b0);
    check("reset_scyc", {s_cyc, s_stb, m0_ack, m1_ack}, 4'b0000);
    @(posedge clk); #1;

    // Tie from reset: m0 first, then strict alternation with one IDLE gap.
    stream_both(4, 40);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_who%0d", i), who[i], exp_who[i]);
      check($sformatf("rr_when%0d", i), when[i], exp_when[i]);
    end

    run_txn(0, 1'b0, 32'h10, '0, 20, st_lat, ak_lat, rd, snap, oth);
    check("rd_stb_lat", st_lat, 1);
    check("rd_ack_lat", ak_lat, 2);
    check("rd_data", rd, 32'h00001234);
    check("rd_no_m1_ack", oth, 1'b0);

    run_txn(1, 1'b1, 32'h40, 32'hCAFEF00D, 20, st_lat, ak_lat, rd, snap, oth);
    check("wr_slave_bus", snap, {1'b1, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D});
    check("wr_ack_lat", ak_lat, 2);
    run_txn(0, 1'b0, 32'h40, '0, 20, st_lat, ak_lat, rd, snap, oth);
    check("wr_readback", rd, 32'hCAFEF00D);

    // Slave ack lands in the same BUSY cycle the watchdog would fire.
    delay = 14;
    run_txn(1, 1'b0, 32'h20, '0, 30, st_lat, ak_lat, rd, snap, oth);
    check("late_ack_lat", ak_lat, 16);
    check("late_ack_data", rd, 32'h20202020);
    @(negedge clk);
    check("late_ack_no_flag", timeout_o, 1'b0);
    @(posedge clk); #1;
    delay = 0;

    hang = 1'b1;
    run_txn(0, 1'b0, 32'h10, '0, 30, st_lat, ak_lat, rd, snap, oth);
    check("tmo_ack_lat", ak_lat, 16);
    check("tmo_data", rd, TMO_DATA);
    @(negedge clk);
    check("tmo_flag_set", timeout_o, 1'b1);
    repeat (2) @(negedge clk);
    check("tmo_flag_sticky", timeout_o, 1'b1);
    @(posedge clk); #1 timeout_clr_i = 1'b1;
    @(posedge clk); #1 timeout_clr_i = 1'b0;
    @(negedge clk);
    check("tmo_flag_clear", timeout_o, 1'b0);
    @(posedge clk); #1;

    // Clear held across a fresh timeout: the set must win.
    timeout_clr_i = 1'b1;
    run_txn(1, 1'b0, 32'h20, '0, 30, st_lat, ak_lat, rd, snap, oth);
    check("tmo_m1_data", rd, TMO_DATA);
    @(negedge clk);
    check("tmo_set_wins", timeout_o, 1'b1);
    @(posedge clk); #1 timeout_clr_i = 1'b0;
    @(negedge clk);
    check("tmo_clr_after", timeout_o, 1'b0);
    @(posedge clk); #1;
    hang = 1'b0;

    // Abort: m1 served last, m0 drops cyc one cycle into BUSY.
    run_txn(1, 1'b0, 32'h20, '0, 20, st_lat, ak_lat, rd, snap, oth);
    check("pre_abort_m1", ak_lat, 2);
    drive_master(0, 1'b1, 1'b0, 32'h10, '0);
    @(posedge clk); #1;
    check("abort_busy_scyc", s_cyc, 1'b1);
    m0_cyc = 1'b0;
    #1 check("abort_scyc_drop", s_cyc, 1'b0);
    seen = 1'b0;
    @(negedge clk); seen |= m0_ack;
    @(negedge clk); seen |= m0_ack;
    check("abort_no_ack", seen, 1'b0);
    check("abort_idle_grant", grant_o, 2'b00);
    @(posedge clk); #1 m0_stb = 1'b0;
    stream_both(2, 20);
    check("abort_tie_who", who[0], 0);
    check("abort_tie_when", when[0], 2);

    // Reset in the middle of a hung transaction, with m0 served last.
    run_txn(0, 1'b0, 32'h10, '0, 20, st_lat, ak_lat, rd, snap, oth);
    hang = 1'b1;
    drive_master(0, 1'b1, 1'b0, 32'h10, '0);
    @(posedge clk); #2;
    check("pre_rst_busy", {s_cyc, grant_o}, 3'b101);
    rst = 1'b1;
    #1 check("rst_outputs",
             {s_cyc, s_stb, s_we, s_addr, s_data_o, m0_ack, m1_ack, m0_data_o, m1_data_o, grant_o, timeout_o},
             '0);
    drive_master(0, 1'b0, 1'b0, '0, '0);
    hang = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    stream_both(2, 20);
    check("post_rst_tie_who", who[0], 0);
    check("post_rst_tie_who2", who[1], 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got time %0t required finish earlier", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule
